// File: rtl/ddr3_rd_capture_x2_if.sv
// ddr3_rd_capture_x2_if
// Bundles the command, DQ and burst-result signals of the x2 read-capture block.
//   RD_CMD   : one-cycle BL8 read-issued pulse
//   RD_LAT   : SCLK cycles from RD_CMD to first beat group
//   DQ_IN    : beats 0..3 of the current SCLK, beat 0 in LSBs
//   ERR_CLR  : synchronous clear of RD_ERR
//   RD_DATA  : assembled 8-beat burst, beat 0 in LSBs
//   RD_VALID : one-cycle strobe qualifying RD_DATA
//   RD_ERR   : sticky error flag
//   BUSY     : a read is in flight or being assembled
// Handshake: there is no back-pressure. RD_VALID is a single-cycle strobe; the
// consumer must take RD_DATA in the cycle RD_VALID is high. RD_DATA holds its
// value afterwards until the next strobe.
// Modports: master = controller side driving commands, slave = capture block.
interface ddr3_rd_capture_x2_if #(
    parameter int DQ_WIDTH = 8,
    parameter int LAT_W    = 5
);
    logic                  RD_CMD;
    logic [LAT_W-1:0]      RD_LAT;
    logic [4*DQ_WIDTH-1:0] DQ_IN;
    logic                  ERR_CLR;
    logic [8*DQ_WIDTH-1:0] RD_DATA;
    logic                  RD_VALID;
    logic                  RD_ERR;
    logic                  BUSY;

    modport master (
        output RD_CMD, RD_LAT, DQ_IN, ERR_CLR,
        input  RD_DATA, RD_VALID, RD_ERR, BUSY
    );

    modport slave (
        input  RD_CMD, RD_LAT, DQ_IN, ERR_CLR,
        output RD_DATA, RD_VALID, RD_ERR, BUSY
    );
endinterface

// File: rtl/ddr3_rd_capture_x2.sv
// ddr3_rd_capture_x2
// Read-path burst assembler for the x2-geared DDR3 PHY. Each accepted BL8 read
// travels down a latency pipe; when it reaches the RD_LAT tap the block captures
// two consecutive 4-beat groups from DQ_IN and emits one 8-beat word with a
// single-cycle RD_VALID strobe.
// Ports:
//   SCLK        : system clock
//   RSTN        : asynchronous active-low reset
//   bus         : ddr3_rd_capture_x2_if slave modport (command, DQ, burst result)
//   o_dbg_state : current capture FSM state (0 = IDLE, 1 = HI)
module ddr3_rd_capture_x2 #(
    parameter int DQ_WIDTH = 8,
    parameter int LAT_W    = 5
) (
    input  logic                 SCLK,
    input  logic                 RSTN,
    ddr3_rd_capture_x2_if.slave  bus,
    output logic                 o_dbg_state
);
    localparam int DEPTH  = 2 ** LAT_W;
    localparam int BEAT_W = 4 * DQ_WIDTH;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HI   = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DEPTH-1:0]    r_pipe;
    logic [DEPTH-1:0]    w_pipe_nxt;
    logic                r_acc_prev;
    logic                w_acc;
    logic                w_rej;
    logic [LAT_W-1:0]    w_lat;
    logic                w_tap;
    logic                w_load_lo;
    logic                w_emit;
    logic                w_hi_tap;
    logic [BEAT_W-1:0]   r_lo;
    logic [2*BEAT_W-1:0] r_data;
    logic                r_valid;
    logic                r_err;

    // Effective latency never drops below 2: a burst needs one cycle to load
    // lo before the HI cycle, and tCCD=2 keeps taps at least 2 cycles apart.
    always_comb begin
        w_lat = bus.RD_LAT;
        if (bus.RD_LAT < LAT_W'(2)) begin
            w_lat = LAT_W'(2);
        end
    end

    assign w_tap = r_pipe[w_lat - LAT_W'(1)];

    // A command in the cycle right after an accepted one violates tCCD.
    assign w_acc = bus.RD_CMD & ~r_acc_prev;
    assign w_rej = bus.RD_CMD &  r_acc_prev;

    // Bits past the tap are dropped so BUSY falls as soon as the last burst
    // has left the HI state instead of waiting for the full pipe to drain.
    always_comb begin
        w_pipe_nxt    = '0;
        w_pipe_nxt[0] = w_acc;
        for (int i = 1; i < DEPTH; i++) begin
            if (LAT_W'(i) < w_lat) begin
                w_pipe_nxt[i] = r_pipe[i-1];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_lo   = 1'b0;
        w_emit      = 1'b0;
        w_hi_tap    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tap) begin
                    w_load_lo   = 1'b1;
                    w_state_nxt = S_HI;
                end
            end
            S_HI: begin
                w_emit      = 1'b1;
                // A tap here would mean two reads one cycle apart slipped
                // through; flag it and drop the newer one.
                w_hi_tap    = w_tap;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= S_IDLE;
            r_pipe     <= '0;
            r_acc_prev <= 1'b0;
            r_lo       <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pipe     <= w_pipe_nxt;
            r_acc_prev <= w_acc;
            r_valid    <= w_emit;
            if (w_load_lo) begin
                r_lo <= bus.DQ_IN;
            end
            if (w_emit) begin
                r_data <= {bus.DQ_IN, r_lo};
            end
            // Set has priority over clear.
            if (w_rej || w_hi_tap) begin
                r_err <= 1'b1;
            end else if (bus.ERR_CLR) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.RD_DATA  = r_data;
    assign bus.RD_VALID = r_valid;
    assign bus.RD_ERR   = r_err;
    assign bus.BUSY     = (|r_pipe) | (r_state == S_HI);
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_ddr3_rd_capture_x2.sv
module tb_ddr3_rd_capture_x2;
    localparam int DQW = 8;
    localparam int LW  = 5;
    localparam int NC  = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    logic dbg_state;
    always #5 clk = ~clk;

    ddr3_rd_capture_x2_if #(.DQ_WIDTH(DQW), .LAT_W(LW)) bus ();

    ddr3_rd_capture_x2 #(.DQ_WIDTH(DQW), .LAT_W(LW)) dut (
        .SCLK        (clk),
        .RSTN        (rstn),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];

    // Per-cycle stimulus and expectation tables (cycle index = edges since cycle 0).
    logic [31:0] dq_tab[NC];
    bit          cmd_tab[NC];
    bit          clr_tab[NC];
    bit          rst_tab[NC];
    bit          val_tab[NC];
    int          busy_tab[NC];
    int          err_tab[NC];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_tabs();
        for (int i = 0; i < NC; i++) begin
            dq_tab[i]   = $urandom();
            cmd_tab[i]  = 1'b0;
            clr_tab[i]  = 1'b0;
            rst_tab[i]  = 1'b0;
            val_tab[i]  = 1'b0;
            busy_tab[i] = -1;
            err_tab[i]  = -1;
        end
        exp_q.delete();
    endtask

    // Read issued in cycle c with effective latency l: beats 0..3 must be on
    // DQ_IN in cycle c+l, beats 4..7 in cycle c+l+1, strobe seen in cycle c+l+2.
    task automatic add_read(input int c, input int l, input logic [31:0] lo, input logic [31:0] hi);
        cmd_tab[c]     = 1'b1;
        dq_tab[c+l]    = lo;
        dq_tab[c+l+1]  = hi;
        val_tab[c+l+2] = 1'b1;
        exp_q.push_back({hi, lo});
    endtask

    task automatic run(input string name, input int n);
        for (int t = 0; t < n; t++) begin
            chk($sformatf("%s valid c%0d", name, t), 64'(bus.RD_VALID), 64'(val_tab[t]));
            if (bus.RD_VALID && val_tab[t]) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("%s strobe without expected word c%0d", name, t), 64'(1), 64'(0));
                end else begin
                    chk($sformatf("%s data c%0d", name, t), bus.RD_DATA, exp_q.pop_front());
                end
            end
            if (busy_tab[t] >= 0) begin
                chk($sformatf("%s busy c%0d", name, t), 64'(bus.BUSY), 64'(busy_tab[t]));
            end
            if (err_tab[t] >= 0) begin
                chk($sformatf("%s err c%0d", name, t), 64'(bus.RD_ERR), 64'(err_tab[t]));
            end
            bus.RD_CMD  = cmd_tab[t];
            bus.DQ_IN   = dq_tab[t];
            bus.ERR_CLR = clr_tab[t];
            rstn        = ~rst_tab[t];
            if (rst_tab[t]) begin
                #1;
                chk($sformatf("%s rst data c%0d", name, t), bus.RD_DATA, 64'(0));
                chk($sformatf("%s rst valid c%0d", name, t), 64'(bus.RD_VALID), 64'(0));
                chk($sformatf("%s rst err c%0d", name, t), 64'(bus.RD_ERR), 64'(0));
                chk($sformatf("%s rst busy c%0d", name, t), 64'(bus.BUSY), 64'(0));
                chk($sformatf("%s rst state c%0d", name, t), 64'(dbg_state), 64'(0));
            end
            @(posedge clk);
            #1;
        end
        chk($sformatf("%s queue drained", name), 64'(exp_q.size()), 64'(0));
        bus.RD_CMD  = 1'b0;
        bus.ERR_CLR = 1'b0;
        rstn        = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    int lat_list[5] = '{0, 1, 2, 17, 31};

    initial begin
        logic [7:0] one;
        int         eff;

        rstn        = 1'b0;
        bus.RD_CMD  = 1'b0;
        bus.RD_LAT  = LW'(2);
        bus.DQ_IN   = '0;
        bus.ERR_CLR = 1'b0;
        #2;
        chk("reset data", bus.RD_DATA, 64'(0));
        chk("reset valid", 64'(bus.RD_VALID), 64'(0));
        chk("reset err", 64'(bus.RD_ERR), 64'(0));
        chk("reset busy", 64'(bus.BUSY), 64'(0));
        chk("reset state", 64'(dbg_state), 64'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single read, latency 5, command in cycle 10.
        clear_tabs();
        bus.RD_LAT = LW'(5);
        add_read(10, 5, 32'h03020100, 32'h07060504);
        busy_tab[10] = 0;
        busy_tab[11] = 1;
        busy_tab[16] = 1;
        busy_tab[17] = 0;
        run("single", 22);

        // Back-to-back reads at tCCD.
        clear_tabs();
        bus.RD_LAT = LW'(4);
        add_read(0, 4, 32'hA3A2A1A0, 32'hA7A6A5A4);
        add_read(2, 4, 32'hB3B2B1B0, 32'hB7B6B5B4);
        add_read(4, 4, 32'hC3C2C1C0, 32'hC7C6C5C4);
        busy_tab[9]  = 1;
        busy_tab[10] = 0;
        err_tab[12]  = 0;
        run("b2b", 14);

        // Collision, clear, and clear losing to a new collision.
        clear_tabs();
        bus.RD_LAT = LW'(4);
        add_read(0, 4, 32'h13121110, 32'h17161514);
        cmd_tab[1]  = 1'b1;
        err_tab[1]  = 0;
        err_tab[2]  = 1;
        err_tab[8]  = 1;
        clr_tab[8]  = 1'b1;
        err_tab[9]  = 0;
        add_read(10, 4, 32'h23222120, 32'h27262524);
        cmd_tab[11] = 1'b1;
        clr_tab[11] = 1'b1;
        err_tab[12] = 1;
        err_tab[13] = 1;
        run("collide", 20);

        // Walking one across all eight beats.
        clear_tabs();
        bus.RD_LAT = LW'(3);
        add_read(0, 3, 32'h08040201, 32'h80402010);
        run("walk", 10);
        for (int b = 0; b < 8; b++) begin
            one = 8'h01;
            chk($sformatf("walk beat%0d", b), 64'(bus.RD_DATA[b*DQW +: DQW]), 64'(one << b));
        end

        // Latency sweep including the clamped values.
        foreach (lat_list[k]) begin
            clear_tabs();
            bus.RD_LAT = LW'(lat_list[k]);
            eff = (lat_list[k] < 2) ? 2 : lat_list[k];
            add_read(0, eff, 32'h5A000000 | 32'(k), 32'hC3000000 | 32'(k));
            run($sformatf("lat%0d", lat_list[k]), eff + 8);
        end

        // Reset mid-flight, then a normal read.
        clear_tabs();
        bus.RD_LAT  = LW'(6);
        cmd_tab[0]  = 1'b1;
        busy_tab[3] = 1;
        rst_tab[4]  = 1'b1;
        busy_tab[6] = 0;
        err_tab[6]  = 0;
        add_read(16, 6, 32'hDEADBEEF, 32'hCAFEF00D);
        run("rst", 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
